// File: rtl/mem_scan_ctrl.sv
// Scanned register memory: a free-running period counter reads one word per period
// for display and commits a pending write once per period. MEM_SCAN_DOWN_EN enables scan_dir.
module mem_scan_ctrl #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              scan_en,
  input  logic              scan_dir,
  input  logic              scan_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              tick,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] RD_PT = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] WR_PT = CNT_W'(TICK_DIV / 2 - 1);

  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] scan_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_pt;
  logic              wr_pt;

  assign rd_pt = (count == RD_PT);
  assign wr_pt = (count == WR_PT);

`ifdef MEM_SCAN_DOWN_EN
  always_comb begin
    scan_next = scan_addr + ADDR_W'(1);
    if (scan_dir)
      scan_next = scan_addr - ADDR_W'(1);
  end
`else
  logic unused_dir;
  assign unused_dir = scan_dir;

  always_comb begin
    scan_next = scan_addr + ADDR_W'(1);
  end
`endif

  // Memory shares the reset-gated block so a write point at count 0 (TICK_DIV=2)
  // cannot commit while RESET is held; the memory itself is never cleared.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      count     <= '0;
      scan_addr <= '0;
      disp_addr <= '0;
      disp_data <= '0;
      tick      <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      count  <= rd_pt ? '0 : count + CNT_W'(1);
      tick   <= rd_pt;
      wr_ack <= wr_pt && wr_req;

      if (wr_pt && wr_req)
        mem[wr_addr] <= wr_data;

      if (rd_pt) begin
        disp_addr <= scan_addr;
        disp_data <= mem[scan_addr];
      end

      if (scan_load)
        scan_addr <= load_addr;
      else if (rd_pt && scan_en)
        scan_addr <= scan_next;
    end
  end

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed bench for mem_scan_ctrl at TICK_DIV=8; tracks the period phase itself and
// checks ticks, write acks and displayed address/data at hand-computed cycles.
module tb_mem_scan_ctrl;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 5;
  localparam int TICK_DIV = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              scan_en;
  logic              scan_dir;
  logic              scan_load;
  logic [ADDR_W-1:0] load_addr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              tick;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned phase = 0;

  mem_scan_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .scan_en  (scan_en),
    .scan_dir (scan_dir),
    .scan_load(scan_load),
    .load_addr(load_addr),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .tick     (tick),
    .disp_addr(disp_addr),
    .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // phase = counter value in the cycle that follows the edge just taken
  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % TICK_DIV;
  endtask

  task automatic run_to(input int unsigned p);
    for (int unsigned i = 0; i < TICK_DIV; i++) begin
      step();
      if (phase == p) break;
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    phase = 0;
  endtask

  logic [ADDR_W-1:0] exp_dn1;
  logic [ADDR_W-1:0] exp_dn2;

  initial begin
`ifdef MEM_SCAN_DOWN_EN
    exp_dn1 = 5'd31;
    exp_dn2 = 5'd30;
`else
    exp_dn1 = 5'd1;
    exp_dn2 = 5'd2;
`endif
    rst = 1'b1; scan_en = 1'b0; scan_dir = 1'b0; scan_load = 1'b0; load_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;

    #2;
    check("rst_tick", tick, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_addr", disp_addr, 0);
    check("rst_data", disp_data, 0);
    repeat (2) @(posedge clk);
    release_reset();

    // held write commits at the count-3 edge; then read it back without scanning
    wr_req = 1'b1; wr_addr = 5'd3; wr_data = 4'hA;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ack_early", wr_ack, 0);
    end
    step();
    check("ack_pt", wr_ack, 1);
    wr_req = 1'b0; scan_load = 1'b1; load_addr = 5'd3; scan_en = 1'b0;
    step();
    check("ack_pulse", wr_ack, 0);
    scan_load = 1'b0;
    run_to(7);
    check("tick_idle", tick, 0);
    step();
    check("tick_pt", tick, 1);
    check("rd_addr3", disp_addr, 3);
    check("rd_data3", disp_data, 4'hA);
    step();
    check("tick_pulse", tick, 0);

    // upward wrap from the top address
    scan_en = 1'b1; scan_dir = 1'b0; scan_load = 1'b1; load_addr = 5'd31;
    step();
    scan_load = 1'b0;
    run_to(0); check("up_31", disp_addr, 31);
    run_to(0); check("up_0", disp_addr, 0);
    run_to(0); check("up_1", disp_addr, 1);

    // downward wrap from address 0 (upward when the option is compiled out)
    step();
    scan_dir = 1'b1; scan_load = 1'b1; load_addr = 5'd0;
    step();
    scan_load = 1'b0;
    run_to(0); check("dn_0", disp_addr, 0);
    run_to(0); check("dn_1", disp_addr, exp_dn1);
    run_to(0); check("dn_2", disp_addr, exp_dn2);

    // load on the read-point cycle: read uses old address, load beats increment
    step();
    scan_dir = 1'b0; scan_en = 1'b1; scan_load = 1'b1; load_addr = 5'd5;
    step();
    scan_load = 1'b0;
    run_to(7);
    scan_load = 1'b1; load_addr = 5'd10;
    step();
    scan_load = 1'b0;
    check("ld_old", disp_addr, 5);
    run_to(0); check("ld_new", disp_addr, 10);
    run_to(0); check("ld_adv", disp_addr, 11);

    // late request waits for the next write point; a held request writes again
    scan_en = 1'b0;
    run_to(5);
    wr_req = 1'b1; wr_addr = 5'd9; wr_data = 4'h6;
    for (int i = 0; i < 6; i++) begin
      step();
      check("late_wait", wr_ack, 0);
    end
    step();
    check("late_ack", wr_ack, 1);
    wr_data = 4'hC;
    step();
    check("hold_gap", wr_ack, 0);
    run_to(4);
    check("hold_ack", wr_ack, 1);
    wr_req = 1'b0; scan_load = 1'b1; load_addr = 5'd9;
    step();
    scan_load = 1'b0;
    check("hold_done", wr_ack, 0);
    run_to(0);
    check("rd_addr9", disp_addr, 9);
    check("rd_data9", disp_data, 4'hC);

    // reset mid-period with a pending write
    run_to(2);
    wr_req = 1'b1; wr_addr = 5'd9; wr_data = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr", disp_addr, 0);
    check("arst_data", disp_data, 0);
    check("arst_ack", wr_ack, 0);
    check("arst_tick", tick, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_noack", wr_ack, 0);
    wr_req = 1'b0;
    release_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      check("post_tick", tick, 0);
      check("post_ack", wr_ack, 0);
    end
    step();
    check("post_first", tick, 1);
    check("post_addr", disp_addr, 0);
    scan_load = 1'b1; load_addr = 5'd9;
    step();
    scan_load = 1'b0;
    run_to(0);
    check("keep_addr", disp_addr, 9);
    check("keep_data", disp_data, 4'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
